// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO read-side stream master.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer that absorbs the FIFO's registered read latency.
// Head entry is always presented; push and pop may occur in the same cycle.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [OCC_W-1:0] occ_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0]      mem_q [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SKID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    // NOTE: every variable gets its default before the conditionals so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + SKID_PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + SKID_PTR_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            // NOTE: storage is reset (only two words) so the stream data output reads 0 out of reset.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: credit-limited reads into a skid buffer,
// presented as a valid/ready stream with frame markers, a read counter and a sticky underflow flag.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FRAME_LEN  = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [CNT_W-1:0]      words_read,
    output logic                  underflow_err,
    input  logic                  clr_err
);

    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    rd_state_t         state_q, state_d;
    logic              rd_inflight_q;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  words_read_q, words_read_d;
    logic              underflow_err_q, underflow_err_d;

    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    credit_used;
    logic              pop;

    fifo_rd_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_inflight_q),
        .push_data_i (fifo_data_out),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (m_data)
    );

    assign m_valid     = (occ != '0);
    assign pop         = m_valid && m_ready;
    assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, rd_inflight_q};

    // A pop in the same cycle frees a slot, which is what sustains one word per cycle.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (state_q == RD_RUN && !fifo_empty) begin
            fifo_rd_en = (credit_used < (OCC_W + 1)'(SKID_DEPTH)) || pop;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:  if (enable) state_d = RD_RUN;
            RD_RUN:   if (!enable) state_d = RD_DRAIN;
            RD_DRAIN: begin
                if (enable) begin
                    state_d = RD_RUN;
                end else if (!rd_inflight_q && occ == '0) begin
                    state_d = RD_IDLE;
                end
            end
            default:  state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        beat_cnt_d      = beat_cnt_q;
        words_read_d    = words_read_q;
        underflow_err_d = underflow_err_q;
        if (pop) begin
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BEAT_W'(1);
        end
        if (fifo_rd_en) begin
            words_read_d = words_read_q + CNT_W'(1);
        end
        // Set has priority over clear.
        if (fifo_underflow) begin
            underflow_err_d = 1'b1;
        end else if (clr_err) begin
            underflow_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RD_IDLE;
            rd_inflight_q   <= 1'b0;
            beat_cnt_q      <= '0;
            words_read_q    <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_inflight_q   <= fifo_rd_en;
            beat_cnt_q      <= beat_cnt_d;
            words_read_q    <= words_read_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign m_last        = m_valid && (beat_cnt_q == LAST_BEAT);
    assign busy          = (state_q != RD_IDLE);
    assign words_read    = words_read_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO with registered read, cycle tables,
// hand-written corner sequences and a randomized run against an in-order scoreboard.
module tb_fifo_stream_reader;

    localparam int W     = 16;
    localparam int FLEN  = 8;
    localparam int CNT_W = 4;

    typedef struct {
        logic          m_ready;
        logic          rd_en;
        logic          valid;
        logic [W-1:0]  data;
        logic          last;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             fifo_rd_en;
    logic [W-1:0]     fifo_data_out;
    logic             fifo_empty;
    logic             fifo_underflow = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [W-1:0]     m_data;
    logic             m_last;
    logic             busy;
    logic [CNT_W-1:0] words_read;
    logic             underflow_err;
    logic             clr_err = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_empty_viol = 0;

    fifo_stream_reader #(
        .FIFO_WIDTH (W),
        .FRAME_LEN  (FLEN),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .busy           (busy),
        .words_read     (words_read),
        .underflow_err  (underflow_err),
        .clr_err        (clr_err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: writes come from the stimulus, reads have one cycle of latency.
    logic [W-1:0] fmem [1024];
    int unsigned  fwr = 0;
    int unsigned  frd = 0;

    assign fifo_empty = (fwr == frd);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frd           <= fwr;
            fifo_data_out <= '0;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= fmem[frd[9:0]];
            frd           <= frd + 1;
        end
    end

    always @(posedge clk) begin
        if (!rst && fifo_rd_en && fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] d);
        fmem[fwr[9:0]] = d;
        fwr = fwr + 1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic mr, input logic rd, input logic v,
                                input logic [W-1:0] d, input logic l);
        vec_t r;
        r.m_ready = mr;
        r.rd_en   = rd;
        r.valid   = v;
        r.data    = d;
        r.last    = l;
        return r;
    endfunction

    task automatic apply_row(input string tag, input int k, input vec_t v);
        m_ready = v.m_ready;
        #1;
        check($sformatf("%s[%0d] rd_en", tag, k), fifo_rd_en, v.rd_en);
        check($sformatf("%s[%0d] m_valid", tag, k), m_valid, v.valid);
        if (v.valid) check($sformatf("%s[%0d] m_data", tag, k), m_data, v.data);
        check($sformatf("%s[%0d] m_last", tag, k), m_last, v.last);
    endtask

    // Scoreboard state for the randomized run.
    logic [W-1:0] exp_q[$];
    int           beat = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic sb_step();
        if (m_valid) begin
            check("rand valid backed by model", (exp_q.size() != 0), 1);
            if (prev_stall) check("rand data stable under stall", m_data, prev_data);
            if (exp_q.size() != 0) begin
                check("rand data order", m_data, exp_q[0]);
                check("rand m_last", m_last, ((beat % FLEN) == FLEN - 1));
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    beat++;
                end
            end
        end else begin
            check("rand m_last idle", m_last, 0);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
    endtask

    vec_t t2 [11];
    vec_t t3 [14];

    initial begin
        int          beats;
        int          n;
        int unsigned total_loaded;
        logic [W-1:0] d;

        for (int k = 0; k < 11; k++) begin
            t2[k] = mk(1'b1, (k <= 7), (k >= 2 && k <= 9), W'(16'hA000 + k - 2), (k == 9));
        end
        t3[0]  = mk(0, 1, 0, 16'h0000, 0);
        t3[1]  = mk(0, 1, 0, 16'h0000, 0);
        t3[2]  = mk(0, 0, 1, 16'hB000, 0);
        t3[3]  = mk(0, 0, 1, 16'hB000, 0);
        t3[4]  = mk(0, 0, 1, 16'hB000, 0);
        t3[5]  = mk(1, 1, 1, 16'hB000, 0);
        t3[6]  = mk(1, 1, 1, 16'hB001, 0);
        t3[7]  = mk(1, 1, 1, 16'hB002, 0);
        t3[8]  = mk(1, 1, 1, 16'hB003, 0);
        t3[9]  = mk(1, 1, 1, 16'hB004, 0);
        t3[10] = mk(1, 1, 1, 16'hB005, 0);
        t3[11] = mk(1, 0, 1, 16'hB006, 0);
        t3[12] = mk(1, 0, 1, 16'hB007, 1);
        t3[13] = mk(1, 0, 0, 16'h0000, 0);

        // T1: reset held with a non-empty FIFO and enable high.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) load(W'(16'h1100 + i));
        enable  = 1'b1;
        m_ready = 1'b1;
        #1;
        check("T1 rd_en", fifo_rd_en, 0);
        check("T1 m_valid", m_valid, 0);
        check("T1 m_data", m_data, 0);
        check("T1 m_last", m_last, 0);
        check("T1 busy", busy, 0);
        check("T1 words_read", words_read, 0);
        check("T1 underflow_err", underflow_err, 0);
        reset_dut();

        // T2: eight preloaded words streamed at full rate.
        @(negedge clk);
        for (int i = 0; i < 8; i++) load(W'(16'hA000 + i));
        @(negedge clk);
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            apply_row("T2", k, t2[k]);
        end
        check("T2 words_read", words_read, 8);

        // T3: consumer stalled, credit stops reads at two, then release.
        @(negedge clk);
        for (int i = 0; i < 8; i++) load(W'(16'hB000 + i));
        apply_row("T3", 0, t3[0]);
        for (int k = 1; k < 14; k++) begin
            @(negedge clk);
            apply_row("T3", k, t3[k]);
        end
        check("T3 words_read wrapped", words_read, 0);

        // T4: single-word FIFO, then sticky underflow flag behaviour.
        @(negedge clk);
        load(16'h4444);
        #1;
        check("T4 c0 rd_en", fifo_rd_en, 1);
        @(negedge clk); #1;
        check("T4 c1 rd_en", fifo_rd_en, 0);
        check("T4 c1 m_valid", m_valid, 0);
        @(negedge clk); #1;
        check("T4 c2 rd_en", fifo_rd_en, 0);
        check("T4 c2 m_valid", m_valid, 1);
        check("T4 c2 m_data", m_data, 16'h4444);
        @(negedge clk); #1;
        check("T4 c3 m_valid", m_valid, 0);
        check("T4 no spurious err", underflow_err, 0);
        @(negedge clk); fifo_underflow = 1'b1; #1;
        check("T4 err before edge", underflow_err, 0);
        @(negedge clk); fifo_underflow = 1'b0; #1;
        check("T4 err set", underflow_err, 1);
        @(negedge clk); clr_err = 1'b1; #1;
        check("T4 err held", underflow_err, 1);
        @(negedge clk); clr_err = 1'b0; #1;
        check("T4 err cleared", underflow_err, 0);
        @(negedge clk); fifo_underflow = 1'b1; clr_err = 1'b1;
        @(negedge clk); fifo_underflow = 1'b0; clr_err = 1'b0; #1;
        check("T4 set wins over clear", underflow_err, 1);
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0; #1;
        check("T4 err cleared again", underflow_err, 0);

        // T5: enable dropped one cycle after the first read.
        @(negedge clk);
        for (int i = 0; i < 3; i++) load(W'(16'h5551 + i));
        #1;
        check("T5 c0 rd_en", fifo_rd_en, 1);
        @(negedge clk); enable = 1'b0; #1;
        check("T5 c1 rd_en", fifo_rd_en, 1);
        @(negedge clk); #1;
        check("T5 c2 rd_en", fifo_rd_en, 0);
        check("T5 c2 m_valid", m_valid, 1);
        check("T5 c2 m_data", m_data, 16'h5551);
        check("T5 c2 busy", busy, 1);
        @(negedge clk); #1;
        check("T5 c3 rd_en", fifo_rd_en, 0);
        check("T5 c3 m_data", m_data, 16'h5552);
        check("T5 c3 m_last", m_last, 0);
        @(negedge clk); #1;
        check("T5 c4 m_valid", m_valid, 0);
        check("T5 c4 busy", busy, 1);
        @(negedge clk); #1;
        check("T5 c5 busy", busy, 0);
        check("T5 c5 rd_en", fifo_rd_en, 0);
        check("T5 words_read", words_read, 3);
        reset_dut();

        // T6a: 17 reads wrap the 4-bit counter to 1.
        @(negedge clk);
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) load(W'(16'h6000 + i));
        beats = 0;
        for (int i = 0; i < 100 && beats < 17; i++) begin
            @(negedge clk); #1;
            if (m_valid && m_ready) begin
                check("T6 data order", m_data, W'(16'h6000 + beats));
                beats++;
            end
        end
        check("T6 all beats delivered", beats, 17);
        repeat (2) @(negedge clk);
        #1;
        check("T6 words_read wrap", words_read, 1);
        reset_dut();

        // Randomized traffic against the scoreboard.
        total_loaded = 0;
        beat = 0;
        prev_stall = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) begin
                n = $urandom_range(3, 1);
                for (int j = 0; j < n; j++) begin
                    d = W'($urandom);
                    load(d);
                    exp_q.push_back(d);
                    total_loaded++;
                end
            end
            enable  = ($urandom_range(9) != 0);
            m_ready = ($urandom_range(9) < 7);
            #1;
            sb_step();
        end
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            sb_step();
            if (exp_q.size() == 0 && !m_valid && fifo_empty) break;
        end
        check("rand drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        #1;
        check("rand words_read", words_read, CNT_W'(total_loaded));
        check("no read issued while empty", rd_empty_viol, 0);

        // T6b: asynchronous reset with a full skid buffer.
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(W'(16'h7000 + i));
        repeat (5) @(negedge clk);
        #1;
        check("T6 skid full before reset", m_valid, 1);
        check("T6 stall data", m_data, 16'h7000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("T6 async m_valid", m_valid, 0);
        check("T6 async busy", busy, 0);
        check("T6 async words_read", words_read, 0);
        check("T6 async m_data", m_data, 0);
        check("T6 async rd_en", fifo_rd_en, 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("T6 post-reset m_valid", m_valid, 0);
        check("T6 post-reset words_read", words_read, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
